// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a 4-digit multiplexed display scanner.
// The display register is updated only on commit; the scan runs freely from its own prescaler.
module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned SCAN_CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] value,
  input  logic       load,
  input  logic       blank_lz,
  output logic       busy,
  output logic       done,
  output logic [3:0] anode,
  output logic [3:0] selected_digit_data
);

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  state_e state_q, state_d;

  logic [9:0]  shift_q, shift_d;
  logic [15:0] scratch_q, scratch_d;
  logic [15:0] adjusted;
  logic [3:0]  step_q, step_d;
  logic [15:0] disp_q, disp_d;
  logic        done_q, done_d;

  logic [SCAN_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic                  blank_q, blank_d;
  logic [3:0]            anode_q, anode_d;
  logic [3:0]            sel_q, sel_d;
  logic                  wrap;
  logic [3:0]            zero_above;
  logic                  blanked;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (load) state_d = StConvert;
      StConvert: if (step_q == 4'd9) state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs; done is registered so it coincides with the new display contents
  always_comb begin
    busy   = (state_q != StIdle);
    done_d = (state_q == StCommit);
  end

  assign done = done_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                          : scratch_q[4*i +: 4];
    end
  end

  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    step_d    = step_q;
    disp_d    = disp_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shift_d   = value;
          scratch_d = '0;
          step_d    = '0;
        end
      end
      StConvert: begin
        {scratch_d, shift_d} = {adjusted[14:0], shift_q, 1'b0};
        step_d               = step_q + 4'd1;
      end
      StCommit: disp_d = scratch_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      disp_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
    end
  end

  // Scan outputs are computed from next-state values so they track a commit on the same edge
  always_comb begin
    wrap    = (cnt_q == SCAN_CNT_W'(SCAN_DIV - 1));
    cnt_d   = wrap ? '0 : cnt_q + SCAN_CNT_W'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    blank_d = wrap ? blank_lz : blank_q;

    zero_above[3] = (disp_d[15:12] == 4'd0);
    zero_above[2] = zero_above[3] & (disp_d[11:8] == 4'd0);
    zero_above[1] = zero_above[2] & (disp_d[7:4] == 4'd0);
    zero_above[0] = zero_above[1] & (disp_d[3:0] == 4'd0);

    blanked = blank_d && (idx_d != 2'd0) && zero_above[idx_d];
    sel_d   = disp_d[{idx_d, 2'b00} +: 4];
    anode_d = blanked ? 4'b1111 : ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      blank_q <= 1'b0;
      anode_q <= 4'b1110;
      sel_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      anode_q <= anode_d;
      sel_q   <= sel_d;
    end
  end

  assign anode               = anode_q;
  assign selected_digit_data = sel_q;

endmodule
